pipeline_ctrl: RTL and testbench

Central hazard and control-flow sequencer for the 5-stage RV32I_Zicsr pipeline.
- Drives the stall and flush inputs of fetch, decode and execute.
- Detects load-use hazards and holds the pipe during data-memory waits.
- Sequences branch/jump redirects, trap entry (mepc/mcause capture, redirect to mtvec) and mret return.
- Sits beside the pipeline registers. It owns no datapath state except the latched PC target and trap values.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline hazard/control sequencer: datapath widths,
// FSM state encodings and the redirect bubble counter width.
package pipeline_ctrl_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int XADDR_DEF = 5;
  localparam int CNT_W     = 3;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags a decode-stage read of a register that the load
// currently in execute has not yet produced.
module pipeline_ctrl_hazard_detect #(
  parameter int XADDR = 5
) (
  input  logic [XADDR-1:0] id_rs1_addr,
  input  logic [XADDR-1:0] id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XADDR-1:0] ex_rd_addr,
  input  logic             ex_is_load,
  input  logic             ex_wr_en,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  // x0 is hard-wired to zero, so a load targeting it can never create a hazard.
  assign load_use = ex_is_load && ex_wr_en && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and control-flow sequencer for the 5-stage pipeline: stalls, flushes,
// branch/mret redirects and trap entry with mepc/mcause capture.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int XADDR        = XADDR_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic             i_ex_is_load,
  input  logic             i_ex_wr_en,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_branch_target,
  input  logic             i_mret,
  input  logic [XLEN-1:0]  i_mepc,
  input  logic             i_trap_req,
  input  logic [XLEN-1:0]  i_trap_pc,
  input  logic [XLEN-1:0]  i_trap_cause,
  input  logic [XLEN-1:0]  i_mtvec,
  input  logic             i_mem_busy,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_pc_redirect,
  output logic [XLEN-1:0]  o_pc_target,
  output logic             o_csr_trap_we,
  output logic [XLEN-1:0]  o_csr_mepc,
  output logic [XLEN-1:0]  o_csr_mcause
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [XLEN-1:0]  mepc_q,   mepc_d;
  logic [XLEN-1:0]  mcause_q, mcause_d;
  logic             active_q;
  logic             load_use;

  pipeline_ctrl_hazard_detect #(.XADDR(XADDR)) u_hazard (
    .id_rs1_addr (i_id_rs1_addr),
    .id_rs2_addr (i_id_rs2_addr),
    .id_uses_rs1 (i_id_uses_rs1),
    .id_uses_rs2 (i_id_uses_rs2),
    .ex_rd_addr  (i_ex_rd_addr),
    .ex_is_load  (i_ex_is_load),
    .ex_wr_en    (i_ex_wr_en),
    .load_use    (load_use)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_flush_id    = 1'b0;
    o_flush_ex    = 1'b0;
    o_pc_redirect = 1'b0;
    o_csr_trap_we = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Inputs are ignored until the first clock edge after reset release.
        if (active_q) begin
          if (i_trap_req) begin
            state_d  = ST_TRAP;
            mepc_d   = i_trap_pc;
            mcause_d = i_trap_cause;
            target_d = i_mtvec & ~XLEN'(3);
          end else if (i_mret) begin
            state_d  = ST_REDIRECT;
            cnt_d    = CNT_LOAD;
            target_d = i_mepc;
          end else if (i_branch_taken) begin
            state_d  = ST_REDIRECT;
            cnt_d    = CNT_LOAD;
            target_d = i_branch_target;
          end else if (i_mem_busy) begin
            state_d    = ST_MEM_WAIT;
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_stall_ex = 1'b1;
          end else if (load_use) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
          end
        end
      end

      ST_MEM_WAIT: begin
        o_stall_if = i_mem_busy;
        o_stall_id = i_mem_busy;
        o_stall_ex = i_mem_busy;
        if (i_trap_req) begin
          state_d  = ST_TRAP;
          mepc_d   = i_trap_pc;
          mcause_d = i_trap_cause;
          target_d = i_mtvec & ~XLEN'(3);
        end else if (!i_mem_busy) begin
          state_d = ST_RUN;
        end
      end

      ST_TRAP: begin
        o_csr_trap_we = 1'b1;
        o_flush_id    = 1'b1;
        o_flush_ex    = 1'b1;
        state_d       = ST_REDIRECT;
        cnt_d         = CNT_LOAD;
      end

      ST_REDIRECT: begin
        o_flush_id    = 1'b1;
        o_flush_ex    = 1'b1;
        o_pc_redirect = (cnt_q == CNT_LOAD);
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign o_pc_target  = target_q;
  assign o_csr_mepc   = mepc_q;
  assign o_csr_mcause = mcause_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      target_q <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, load-use, branch, mret, trap,
// memory wait and event priority, with hand-computed expectations.
module tb_pipeline_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
  logic        i_id_uses_rs1, i_id_uses_rs2, i_ex_is_load, i_ex_wr_en;
  logic        i_branch_taken, i_mret, i_trap_req, i_mem_busy;
  logic [31:0] i_branch_target, i_mepc, i_trap_pc, i_trap_cause, i_mtvec;
  logic        o_stall_if, o_stall_id, o_stall_ex, o_flush_id, o_flush_ex;
  logic        o_pc_redirect, o_csr_trap_we;
  logic [31:0] o_pc_target, o_csr_mepc, o_csr_mcause;

  int total = 0;
  int bad   = 0;

  // Control vector order: {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect, csr_trap_we}
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LU    = 7'b110_0000;
  localparam logic [6:0] C_MEM   = 7'b111_0000;
  localparam logic [6:0] C_TRAP  = 7'b000_1101;
  localparam logic [6:0] C_REDIR = 7'b000_1110;
  localparam logic [6:0] C_FLUSH = 7'b000_1100;

  always #5 i_clk = ~i_clk;

  pipeline_ctrl #(.XLEN(32), .XADDR(5), .FLUSH_CYCLES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_is_load(i_ex_is_load), .i_ex_wr_en(i_ex_wr_en),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_mret(i_mret), .i_mepc(i_mepc),
    .i_trap_req(i_trap_req), .i_trap_pc(i_trap_pc), .i_trap_cause(i_trap_cause),
    .i_mtvec(i_mtvec), .i_mem_busy(i_mem_busy),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_stall_ex(o_stall_ex),
    .o_flush_id(o_flush_id), .o_flush_ex(o_flush_ex),
    .o_pc_redirect(o_pc_redirect), .o_pc_target(o_pc_target),
    .o_csr_trap_we(o_csr_trap_we), .o_csr_mepc(o_csr_mepc), .o_csr_mcause(o_csr_mcause)
  );

  function automatic logic [31:0] ctl();
    return {25'd0, o_stall_if, o_stall_id, o_stall_ex, o_flush_id, o_flush_ex,
            o_pc_redirect, o_csr_trap_we};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_id_uses_rs1 = 0; i_id_uses_rs2 = 0;
    i_ex_rd_addr = '0; i_ex_is_load = 0; i_ex_wr_en = 0;
    i_branch_taken = 0; i_branch_target = '0; i_mret = 0; i_mepc = '0;
    i_trap_req = 0; i_trap_pc = '0; i_trap_cause = '0; i_mtvec = '0; i_mem_busy = 0;
  endtask

  // lw x5 in execute, add reading x5 in decode
  task automatic load_use_inputs();
    i_ex_is_load = 1; i_ex_wr_en = 1; i_ex_rd_addr = 5'd5;
    i_id_rs1_addr = 5'd5; i_id_uses_rs1 = 1;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    load_use_inputs();
    i_rst_n = 1'b0;
    #12;
    check("in_reset_ctl", ctl(), {25'd0, C_NONE});
    check("in_reset_target", o_pc_target, 32'h0);
    @(negedge i_clk); i_rst_n = 1'b1; #1;
    check("first_cycle_after_release", ctl(), {25'd0, C_NONE});

    // Load-use: one stall cycle, then the load has moved on
    cyc(); #1;
    check("load_use_stall", ctl(), {25'd0, C_LU});
    cyc(); idle(); #1;
    check("load_use_cleared", ctl(), {25'd0, C_NONE});
    cyc(); load_use_inputs(); i_ex_rd_addr = 5'd0; i_id_rs1_addr = 5'd0; #1;
    check("load_use_rd0", ctl(), {25'd0, C_NONE});
    cyc(); idle(); load_use_inputs(); i_id_uses_rs1 = 0; i_id_rs2_addr = 5'd5; i_id_uses_rs2 = 1; #1;
    check("load_use_rs2", ctl(), {25'd0, C_LU});
    cyc(); i_id_uses_rs2 = 0; #1;
    check("no_use_no_stall", ctl(), {25'd0, C_NONE});

    // Branch together with a load-use hazard: branch wins, no stall
    cyc(); idle(); load_use_inputs(); i_branch_taken = 1; i_branch_target = 32'h100; #1;
    check("branch_k_no_stall", ctl(), {25'd0, C_NONE});
    cyc(); idle(); i_branch_taken = 1; i_branch_target = 32'h999; #1;
    check("branch_k1_ctl", ctl(), {25'd0, C_REDIR});
    check("branch_k1_target", o_pc_target, 32'h100);
    cyc(); idle(); #1;
    check("branch_k2_ctl", ctl(), {25'd0, C_FLUSH});
    check("branch_k2_target_held", o_pc_target, 32'h100);
    cyc(); #1;
    check("branch_k3_run", ctl(), {25'd0, C_NONE});

    // mret returns to mepc
    cyc(); i_mret = 1; i_mepc = 32'h200; #1;
    check("mret_k", ctl(), {25'd0, C_NONE});
    cyc(); idle(); #1;
    check("mret_k1_ctl", ctl(), {25'd0, C_REDIR});
    check("mret_k1_target", o_pc_target, 32'h200);
    cyc(); #1;
    check("mret_k2_ctl", ctl(), {25'd0, C_FLUSH});
    cyc(); #1;
    check("mret_k3_run", ctl(), {25'd0, C_NONE});

    // Trap entry: CSR write, then redirect to mtvec with mode bits cleared
    cyc(); i_trap_req = 1; i_trap_pc = 32'h40; i_trap_cause = 32'hB; i_mtvec = 32'h803; #1;
    check("trap_k", ctl(), {25'd0, C_NONE});
    cyc(); idle(); #1;
    check("trap_k1_ctl", ctl(), {25'd0, C_TRAP});
    check("trap_k1_mepc", o_csr_mepc, 32'h40);
    check("trap_k1_mcause", o_csr_mcause, 32'hB);
    cyc(); #1;
    check("trap_k2_ctl", ctl(), {25'd0, C_REDIR});
    check("trap_k2_target", o_pc_target, 32'h800);
    cyc(); #1;
    check("trap_k3_ctl", ctl(), {25'd0, C_FLUSH});
    cyc(); #1;
    check("trap_k4_run", ctl(), {25'd0, C_NONE});

    // Memory wait: three busy cycles stall everything, release with no stall
    for (int i = 0; i < 3; i++) begin
      cyc(); i_mem_busy = 1; #1;
      check($sformatf("mem_busy_%0d", i), ctl(), {25'd0, C_MEM});
    end
    cyc(); i_mem_busy = 0; #1;
    check("mem_release", ctl(), {25'd0, C_NONE});
    cyc(); load_use_inputs(); #1;
    check("mem_back_in_run", ctl(), {25'd0, C_LU});

    // Memory wait interrupted by a trap in its second cycle
    cyc(); idle(); i_mem_busy = 1; #1;
    check("memtrap_c1", ctl(), {25'd0, C_MEM});
    cyc(); i_trap_req = 1; i_trap_pc = 32'h44; i_trap_cause = 32'h5; i_mtvec = 32'h900; #1;
    check("memtrap_c2", ctl(), {25'd0, C_MEM});
    cyc(); i_trap_req = 0; #1;
    check("memtrap_trap_ctl", ctl(), {25'd0, C_TRAP});
    check("memtrap_mepc", o_csr_mepc, 32'h44);
    check("memtrap_mcause", o_csr_mcause, 32'h5);
    cyc(); #1;
    check("memtrap_redirect", ctl(), {25'd0, C_REDIR});
    check("memtrap_target", o_pc_target, 32'h900);
    cyc(); idle(); #1;
    check("memtrap_flush", ctl(), {25'd0, C_FLUSH});
    cyc(); #1;
    check("memtrap_run", ctl(), {25'd0, C_NONE});

    // Priority: trap beats mret and branch; neither 0x200 nor 0x300 is redirected to
    cyc(); i_trap_req = 1; i_trap_pc = 32'h80; i_trap_cause = 32'h3; i_mtvec = 32'h1000;
    i_mret = 1; i_mepc = 32'h200; i_branch_taken = 1; i_branch_target = 32'h300; #1;
    check("prio_k", ctl(), {25'd0, C_NONE});
    cyc(); idle(); #1;
    check("prio_k1_ctl", ctl(), {25'd0, C_TRAP});
    check("prio_k1_mepc", o_csr_mepc, 32'h80);
    cyc(); #1;
    check("prio_k2_ctl", ctl(), {25'd0, C_REDIR});
    check("prio_k2_target", o_pc_target, 32'h1000);
    cyc(); #1;
    check("prio_k3_ctl", ctl(), {25'd0, C_FLUSH});
    cyc(); #1;
    check("prio_k4_run", ctl(), {25'd0, C_NONE});

    // Reset in the middle of a redirect abandons it
    cyc(); i_branch_taken = 1; i_branch_target = 32'h500; #1;
    cyc(); idle(); #1;
    check("rst_pre_redirect", ctl(), {25'd0, C_REDIR});
    i_rst_n = 1'b0; #1;
    check("rst_mid_ctl", ctl(), {25'd0, C_NONE});
    check("rst_mid_target", o_pc_target, 32'h0);
    check("rst_mid_mepc", o_csr_mepc, 32'h0);
    cyc(); #1;
    check("rst_held_ctl", ctl(), {25'd0, C_NONE});
    @(negedge i_clk); i_rst_n = 1'b1; load_use_inputs(); #1;
    check("rst_release_ctl", ctl(), {25'd0, C_NONE});
    cyc(); #1;
    check("rst_after_run", ctl(), {25'd0, C_LU});
    cyc(); idle(); #1;
    check("rst_after_idle", ctl(), {25'd0, C_NONE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
